audio_in: RTL and testbench
===========================

Name: audio_in

Overview:
- I2S receiver for the codec ADC path. It deserialises the codec's ADCDAT stream, clocked by codec-generated BCLK/LRCK, into parallel left/right sample pairs.
- Pairs are buffered in a small first-word-fall-through FIFO with a pop handshake, consumed by the audio processing logic.
- It is the capture-side counterpart of the existing DAC serialiser and runs on the same system clock.

Parameters:
- DATA_WIDTH, 24, bits per channel sample, MSB first
- FIFO_DEPTH, 4, sample-pair entries; power of two, >= 2
- SYNC_STAGES, 2, synchroniser flops on bclk, lrck and adcdat

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  asynchronous, active-high; clears all state
- bclk  input  1  codec bit clock, asynchronous to clk, period >= 4 clk
- lrck  input  1  codec ADC LR clock; 0 = left, 1 = right
- adcdat  input  1  codec serial data
- read_enable  input  1  pop head pair; honoured only when sample_valid=1
- left_sample  output  DATA_WIDTH  left sample of FIFO head
- right_sample  output  DATA_WIDTH  right sample of FIFO head
- sample_valid  output  1  FIFO non-empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held
- overflow  output  1  sticky; a pair was dropped because the FIFO was full

Behaviour:
- Reset values: all outputs 0, FIFO empty, pointers 0, shift register 0, bit counter 0, synced=0, left_ready=0.
- Synchronisation
  - bclk, lrck and adcdat each pass through SYNC_STAGES flops.
  - bclk_rise = synced bclk is 1 and its previous value was 0. All capture logic advances only on bclk_rise cycles.
- Framing, I2S format
  - LRCK changes after a BCLK falling edge.
  - The first bclk_rise after an lrck change is the one-bit delay slot and is discarded.
  - The next DATA_WIDTH bclk_rise edges carry MSB..LSB.
  - Further edges before the next lrck change (e.g. 32-bit slots) are ignored.
- Capture state machine: IDLE, DELAY, SHIFT, WAIT.
  - IDLE: entered after reset; waits for the first lrck change (sets synced=1) -> DELAY.
  - DELAY: on bclk_rise, latch channel=lrck_s, clear shift register and bit counter -> SHIFT.
  - SHIFT: on each bclk_rise, shift adcdat_s into the LSB and increment the counter.
    - At count DATA_WIDTH -> WAIT.
    - Left channel: copy word to left_hold, set left_ready.
    - Right channel with left_ready=1: push {left_hold, word} into the FIFO, clear left_ready.
    - Right channel with left_ready=0: discard (start-up or truncated left).
  - WAIT: ignore bits; on lrck change -> DELAY.
  - lrck change detected in SHIFT before count DATA_WIDTH: discard the partial word, clear left_ready, -> DELAY.
- FIFO
  - First-word-fall-through: left_sample/right_sample show the head entry whenever sample_valid=1 and hold 0 when empty.
  - Pop (read_enable & sample_valid) advances the read pointer; the next entry appears on the following cycle.
  - read_enable while empty is ignored.
  - Push when full without a pop: new pair dropped, contents unchanged, overflow set. overflow is cleared only by reset.
  - Push and pop in the same cycle when full: both performed, fifo_count unchanged, overflow not set.
  - Push and pop in the same cycle when count is between 1 and full: both performed, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: sample_valid rises SYNC_STAGES+2 clk after the pin-level BCLK rising edge that carries the right-channel LSB.
- Reset mid-frame: the partial frame is lost and the FSM returns to IDLE. Capture resumes at the next lrck transition; the first right channel after that is discarded unless preceded by a full left channel.

Test Plan:
- Frame with bclk=clk/8, left=24'hA5A5A5, right=24'h5A5A5A, 32 BCLK per channel -> sample_valid=1, left_sample=A5A5A5, right_sample=5A5A5A, fifo_count=1. Pulse read_enable for 1 cycle -> sample_valid=0, outputs 0.
- Five frames (L,R)=(1,2),(3,4),(5,6),(7,8),(9,10) with no reads -> fifo_count=4, overflow=1, head (1,2). Four pops return (1,2)..(7,8) in order; (9,10) never appears.
- FIFO full, read_enable asserted on the push cycle of a sixth frame (11,12) -> fifo_count stays 4, overflow unchanged. Last entry read out is (11,12).
- Left truncated by an lrck toggle after 12 bits, then a full right=24'h123456 -> no push, fifo_count=0. The following complete frame (24'hFFFFFF, 24'h000001) is captured correctly.
- Start-up with lrck=1 (right first) -> the first right word is discarded; the next L/R pair is captured.
- reset asserted mid right-channel shift -> all outputs 0 immediately (async). After release, the next complete frame yields exactly one correct pair.

Source files
------------

// File: rtl/audio_in.sv
// I2S ADC-path receiver: synchronises BCLK/LRCK/ADCDAT into clk, deserialises
// left/right words and queues complete pairs in a first-word-fall-through FIFO.
module audio_in #(
    parameter int DATA_WIDTH  = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bclk,
    input  logic                          lrck,
    input  logic                          adcdat,
    input  logic                          read_enable,
    output logic [DATA_WIDTH-1:0]         left_sample,
    output logic [DATA_WIDTH-1:0]         right_sample,
    output logic                          sample_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SHIFT, S_WAIT} state_t;

    logic [SYNC_STAGES-1:0]  r_bclk_sync, r_lrck_sync, r_dat_sync;
    logic                    r_bclk_prev, r_lrck_prev;
    logic                    w_bclk_s, w_lrck_s, w_dat_s, w_bclk_rise, w_lrck_chg;

    state_t                  r_state, w_next;
    logic                    w_start, w_shift, w_done, w_abort;
    logic [DATA_WIDTH-1:0]   r_shift, r_left_hold, w_word;
    logic [CW-1:0]           r_bit_cnt;
    logic                    r_channel, r_left_ready;
    logic                    r_push_req;
    logic [2*DATA_WIDTH-1:0] r_push_data;

    logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
    logic [PW:0]             r_count;
    logic                    r_overflow;
    logic                    w_pop, w_push, w_full;
    logic [2*DATA_WIDTH-1:0] w_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_prev <= 1'b0;
            r_lrck_prev <= 1'b0;
        end else begin
            r_bclk_sync[0] <= bclk;
            r_lrck_sync[0] <= lrck;
            r_dat_sync[0]  <= adcdat;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_bclk_sync[i] <= r_bclk_sync[i-1];
                r_lrck_sync[i] <= r_lrck_sync[i-1];
                r_dat_sync[i]  <= r_dat_sync[i-1];
            end
            r_bclk_prev <= w_bclk_s;
            r_lrck_prev <= w_lrck_s;
        end
    end

    assign w_bclk_s    = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrck_s    = r_lrck_sync[SYNC_STAGES-1];
    assign w_dat_s     = r_dat_sync[SYNC_STAGES-1];
    assign w_bclk_rise = w_bclk_s & ~r_bclk_prev;
    assign w_lrck_chg  = w_lrck_s ^ r_lrck_prev;
    assign w_word      = {r_shift[DATA_WIDTH-2:0], w_dat_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_shift = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE:  if (w_lrck_chg) w_next = S_DELAY;
            S_DELAY: if (w_bclk_rise) begin
                w_start = 1'b1;
                w_next  = S_SHIFT;
            end
            S_SHIFT: if (w_lrck_chg) begin
                w_abort = 1'b1;
                w_next  = S_DELAY;
            end else if (w_bclk_rise) begin
                w_shift = 1'b1;
                if (r_bit_cnt == CW'(DATA_WIDTH - 1)) begin
                    w_done = 1'b1;
                    w_next = S_WAIT;
                end
            end
            S_WAIT:  if (w_lrck_chg) w_next = S_DELAY;
            default: w_next = S_IDLE;
        endcase
    end

    // Completed pairs are staged one cycle in r_push_req/r_push_data before the FIFO write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_channel    <= 1'b0;
            r_left_hold  <= '0;
            r_left_ready <= 1'b0;
            r_push_req   <= 1'b0;
            r_push_data  <= '0;
        end else begin
            r_push_req <= 1'b0;
            if (w_start) begin
                r_channel <= w_lrck_s;
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end
            if (w_shift) begin
                r_shift   <= w_word;
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
            if (w_abort) r_left_ready <= 1'b0;
            if (w_done) begin
                if (!r_channel) begin
                    r_left_hold  <= w_word;
                    r_left_ready <= 1'b1;
                end else if (r_left_ready) begin
                    r_push_req   <= 1'b1;
                    r_push_data  <= {r_left_hold, w_word};
                    r_left_ready <= 1'b0;
                end
            end
        end
    end

    assign w_full = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_pop  = read_enable & (r_count != '0);
    assign w_push = r_push_req & (~w_full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
            if (r_push_req && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign sample_valid = (r_count != '0);
    assign left_sample  = sample_valid ? w_head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign right_sample = sample_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_audio_in.sv
// Scoreboard bench for audio_in: stimulus queues expected pairs, a negedge
// monitor checks every pop against the queue head.
module tb_audio_in;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bclk = 1'b0;
    logic          lrck = 1'b0;
    logic          adcdat = 1'b0;
    logic          read_enable = 1'b0;
    logic [DW-1:0] left_sample, right_sample;
    logic          sample_valid;
    logic [2:0]    fifo_count;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] mon_e;

    audio_in #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bclk(bclk), .lrck(lrck), .adcdat(adcdat),
        .read_enable(read_enable), .left_sample(left_sample),
        .right_sample(right_sample), .sample_valid(sample_valid),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && read_enable && sample_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h_%0h expected none", left_sample, right_sample);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_left", 64'(left_sample), 64'(mon_e[2*DW-1:DW]));
                chk("pop_right", 64'(right_sample), 64'(mon_e[DW-1:0]));
            end
        end
    end

    // One BCLK period of 8 clk; optionally pops on the FIFO write cycle of this rising edge.
    task automatic drive_bit(input logic b, input logic lr, input bit pop_here);
        @(posedge clk); #1;
        bclk = 1'b0; lrck = lr; adcdat = b;
        repeat (4) @(posedge clk);
        #1 bclk = 1'b1;
        if (pop_here) begin
            repeat (3) @(posedge clk);
            #1 read_enable = 1'b1;
            @(posedge clk);
            #1 read_enable = 1'b0;
        end else begin
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic send_channel(input logic lr, input logic [DW-1:0] data, input int nbits, input int pop_bit);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = (i >= 1 && i <= DW) ? data[DW-i] : 1'b0;
            drive_bit(b, lr, i == pop_bit);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit pop_on_push);
        send_channel(1'b0, l, 32, -1);
        send_channel(1'b1, r, 32, pop_on_push ? DW : -1);
        @(negedge clk);
    endtask

    task automatic pulse_read();
        @(posedge clk); #1 read_enable = 1'b1;
        @(posedge clk); #1 read_enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_valid", 64'(sample_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_left", 64'(left_sample), 64'd0);
        chk("rst_right", 64'(right_sample), 64'd0);
        reset = 1'b0;

        // right-first start-up: lone right word is dropped
        send_channel(1'b1, 24'hDEADBE, 32, -1);
        @(negedge clk);
        chk("startup_discard", 64'(fifo_count), 64'd0);

        exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
        send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0);
        chk("t1_valid", 64'(sample_valid), 64'd1);
        chk("t1_count", 64'(fifo_count), 64'd1);
        chk("t1_left", 64'(left_sample), 64'hA5A5A5);
        chk("t1_right", 64'(right_sample), 64'h5A5A5A);
        pulse_read();
        chk("t1_valid_after", 64'(sample_valid), 64'd0);
        chk("t1_left_zero", 64'(left_sample), 64'd0);
        chk("t1_right_zero", 64'(right_sample), 64'd0);
        pulse_read();
        chk("empty_read_count", 64'(fifo_count), 64'd0);

        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({24'(2*k+1), 24'(2*k+2)});
            send_frame(24'(2*k+1), 24'(2*k+2), 1'b0);
        end
        chk("t2_full_count", 64'(fifo_count), 64'd4);
        chk("t2_no_ovf_yet", 64'(overflow), 64'd0);
        send_frame(24'd9, 24'd10, 1'b0);
        chk("t2_count", 64'(fifo_count), 64'd4);
        chk("t2_ovf", 64'(overflow), 64'd1);
        chk("t2_head_left", 64'(left_sample), 64'd1);
        chk("t2_head_right", 64'(right_sample), 64'd2);

        exp_q.push_back({24'd11, 24'd12});
        send_frame(24'd11, 24'd12, 1'b1);
        chk("t3_count", 64'(fifo_count), 64'd4);
        chk("t3_ovf", 64'(overflow), 64'd1);
        repeat (4) pulse_read();
        chk("t3_drained", 64'(fifo_count), 64'd0);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        send_channel(1'b0, 24'hABCDEF, 13, -1);
        send_channel(1'b1, 24'h123456, 32, -1);
        @(negedge clk);
        chk("t4_trunc_count", 64'(fifo_count), 64'd0);
        exp_q.push_back({24'hFFFFFF, 24'h000001});
        send_frame(24'hFFFFFF, 24'h000001, 1'b0);
        chk("t4_count", 64'(fifo_count), 64'd1);
        pulse_read();

        exp_q.push_back({24'h111111, 24'h222222});
        send_frame(24'h111111, 24'h222222, 1'b0);
        chk("t6_pre_count", 64'(fifo_count), 64'd1);
        send_channel(1'b0, 24'h333333, 32, -1);
        send_channel(1'b1, 24'h444444, 10, -1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(sample_valid), 64'd0);
        chk("t6_rst_count", 64'(fifo_count), 64'd0);
        chk("t6_rst_ovf", 64'(overflow), 64'd0);
        chk("t6_rst_left", 64'(left_sample), 64'd0);
        chk("t6_rst_right", 64'(right_sample), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_channel(1'b1, 24'h555555, 22, -1);
        exp_q.push_back({24'h666666, 24'h777777});
        send_frame(24'h666666, 24'h777777, 1'b0);
        chk("t6_count", 64'(fifo_count), 64'd1);
        chk("t6_ovf", 64'(overflow), 64'd0);
        pulse_read();
        chk("t6_drained", 64'(fifo_count), 64'd0);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
